// File: rtl/bmf_err_pkg.sv
// rtl/bmf_err_pkg.sv - shared types, default widths and saturating-add helpers for bmf_err_monitor
package bmf_err_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int OUT_W_DEF = 4;
    localparam int CNT_W_DEF = 16;
    localparam int ACC_W_DEF = 24;

    // Operands are zero-extended to 64 bits by the caller; max_v is the all-ones value of the target width.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] max_v);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[63:0];
    endfunction

    function automatic logic sat_ovf(input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] max_v);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s > {1'b0, max_v};
    endfunction

endpackage

// File: rtl/bmf_err_monitor_if.sv
// rtl/bmf_err_monitor_if.sv - exact/approx sample stream between partition block and monitor
interface bmf_err_monitor_if #(
    parameter int OUT_W = bmf_err_pkg::OUT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] exact_out;
    logic [OUT_W-1:0] approx_out;

    modport master (output in_valid, output exact_out, output approx_out, input in_ready);
    modport slave  (input in_valid, input exact_out, input approx_out, output in_ready);
endinterface

// File: rtl/bmf_err_sample_stage.sv
// rtl/bmf_err_sample_stage.sv - S1: per-sample xor/popcount/absdiff (and square with BMF_ERR_MONITOR_SQERR_EN)
module bmf_err_sample_stage
    import bmf_err_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int PC_W  = $clog2(OUT_W + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [OUT_W-1:0]   i_exact,
    input  logic [OUT_W-1:0]   i_approx,
    output logic [PC_W-1:0]    o_popcnt,
    output logic [OUT_W-1:0]   o_absdiff,
    output logic               o_neq
`ifdef BMF_ERR_MONITOR_SQERR_EN
    ,
    output logic [2*OUT_W-1:0] o_sqerr
`endif
);
    logic [OUT_W-1:0]   w_xor;
    logic [OUT_W:0]     w_diff;
    logic [OUT_W:0]     w_diff_neg;
    logic [OUT_W-1:0]   w_abs;
    logic [PC_W-1:0]    w_pop;
    logic [OUT_W-1:0]   r_xor;
    logic [PC_W-1:0]    r_pop;
    logic [OUT_W-1:0]   r_abs;

    // One extra bit on the subtract gives the sign; negate when exact < approx.
    always_comb begin
        w_xor      = i_exact ^ i_approx;
        w_pop      = PC_W'($countones(w_xor));
        w_diff     = {1'b0, i_exact} - {1'b0, i_approx};
        w_diff_neg = -w_diff;
        w_abs      = w_diff[OUT_W] ? w_diff_neg[OUT_W-1:0] : w_diff[OUT_W-1:0];
    end

    // Capture only on an accepted pair so stalls leave the stage untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xor <= '0;
            r_pop <= '0;
            r_abs <= '0;
        end else if (i_load) begin
            r_xor <= w_xor;
            r_pop <= w_pop;
            r_abs <= w_abs;
        end
    end

`ifdef BMF_ERR_MONITOR_SQERR_EN
    logic [2*OUT_W-1:0] r_sq;

    // Square of the absolute error, registered alongside the other S1 terms.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sq <= '0;
        end else if (i_load) begin
            r_sq <= (2*OUT_W)'(w_abs) * (2*OUT_W)'(w_abs);
        end
    end

    assign o_sqerr = r_sq;
`endif

    assign o_popcnt  = r_pop;
    assign o_absdiff = r_abs;
    assign o_neq     = |r_xor;

endmodule

// File: rtl/bmf_err_monitor.sv
// rtl/bmf_err_monitor.sv - windowed error-statistics monitor; BMF_ERR_MONITOR_SQERR_EN adds sq_err_sum
module bmf_err_monitor
    import bmf_err_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   win_len,
    bmf_err_monitor_if.slave   s_in,
    output logic               busy,
    output logic               done,
    input  logic               done_ack,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [ACC_W-1:0]   hd_sum,
    output logic [ACC_W-1:0]   abs_err_sum,
    output logic [OUT_W-1:0]   max_abs_err,
    output logic               sat
`ifdef BMF_ERR_MONITOR_SQERR_EN
    ,
    output logic [2*ACC_W-1:0] sq_err_sum
`endif
);
    localparam int          PC_W    = $clog2(OUT_W + 1);
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_target, r_acc_cnt;
    logic               r_s1_valid, r_s2_valid;
    logic               w_in_ready, w_accept, w_clear, w_busy, w_done, w_clamp;
    logic [PC_W-1:0]    w_pop;
    logic [OUT_W-1:0]   w_abs;
    logic               w_neq;
    logic [CNT_W-1:0]   r_sample_cnt, r_err_cnt;
    logic [ACC_W-1:0]   r_hd_sum, r_abs_sum;
    logic [OUT_W-1:0]   r_max;
    logic               r_sat;
`ifdef BMF_ERR_MONITOR_SQERR_EN
    localparam logic [63:0] SQ_MAX = (64'd1 << (2*ACC_W)) - 64'd1;
    logic [2*OUT_W-1:0] w_sq;
    logic [2*ACC_W-1:0] r_sq_sum;
`endif

    assign w_accept = s_in.in_valid & w_in_ready;

    bmf_err_sample_stage #(.OUT_W(OUT_W), .PC_W(PC_W)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept),
        .i_exact   (s_in.exact_out),
        .i_approx  (s_in.approx_out),
        .o_popcnt  (w_pop),
        .o_absdiff (w_abs),
        .o_neq     (w_neq)
`ifdef BMF_ERR_MONITOR_SQERR_EN
        ,
        .o_sqerr   (w_sq)
`endif
    );

    // Window FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and handshake outputs; DRAIN holds until both pipeline stages are empty.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = (win_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy     = 1'b1;
                w_in_ready = (r_acc_cnt < r_target);
                if (w_accept && (r_acc_cnt == r_target - 1'b1)) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (!r_s1_valid && !r_s2_valid) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (done_ack) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Window target, accept counter and pipeline valid tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_target   <= '0;
            r_acc_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            if (w_clear) begin
                r_target  <= win_len;
                r_acc_cnt <= '0;
            end else if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + 1'b1;
            end
        end
    end

    // Any accumulator that would overflow this cycle raises the sticky flag.
    always_comb begin
        w_clamp = sat_ovf(64'(r_sample_cnt), 64'd1, CNT_MAX)
                | sat_ovf(64'(r_err_cnt), 64'(w_neq), CNT_MAX)
                | sat_ovf(64'(r_hd_sum), 64'(w_pop), ACC_MAX)
                | sat_ovf(64'(r_abs_sum), 64'(w_abs), ACC_MAX);
`ifdef BMF_ERR_MONITOR_SQERR_EN
        w_clamp = w_clamp | sat_ovf(64'(r_sq_sum), 64'(w_sq), SQ_MAX);
`endif
    end

    // S2: fold one S1 result into the window statistics, clamping at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_hd_sum     <= '0;
            r_abs_sum    <= '0;
            r_max        <= '0;
            r_sat        <= 1'b0;
`ifdef BMF_ERR_MONITOR_SQERR_EN
            r_sq_sum     <= '0;
`endif
        end else if (r_s1_valid) begin
            r_sample_cnt <= CNT_W'(sat_add(64'(r_sample_cnt), 64'd1, CNT_MAX));
            r_err_cnt    <= CNT_W'(sat_add(64'(r_err_cnt), 64'(w_neq), CNT_MAX));
            r_hd_sum     <= ACC_W'(sat_add(64'(r_hd_sum), 64'(w_pop), ACC_MAX));
            r_abs_sum    <= ACC_W'(sat_add(64'(r_abs_sum), 64'(w_abs), ACC_MAX));
            r_max        <= (w_abs > r_max) ? w_abs : r_max;
            r_sat        <= r_sat | w_clamp;
`ifdef BMF_ERR_MONITOR_SQERR_EN
            r_sq_sum     <= (2*ACC_W)'(sat_add(64'(r_sq_sum), 64'(w_sq), SQ_MAX));
`endif
        end
    end

    assign s_in.in_ready = w_in_ready;
    assign busy          = w_busy;
    assign done          = w_done;
    assign sample_cnt    = r_sample_cnt;
    assign err_cnt       = r_err_cnt;
    assign hd_sum        = r_hd_sum;
    assign abs_err_sum   = r_abs_sum;
    assign max_abs_err   = r_max;
    assign sat           = r_sat;
`ifdef BMF_ERR_MONITOR_SQERR_EN
    assign sq_err_sum    = r_sq_sum;
`endif

endmodule

// File: tb/tb_bmf_err_monitor.sv
// tb/tb_bmf_err_monitor.sv - self-checking bench for bmf_err_monitor (BMF_ERR_MONITOR_SQERR_EN aware)
module tb_bmf_err_monitor;
    localparam int OW  = 4;
    localparam int CW  = 16;
    localparam int AW  = 24;
    localparam int CWB = 4;
    localparam int AWB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           start_a, done_ack_a, busy_a, done_a, sat_a;
    logic [CW-1:0]  win_len_a, sample_cnt_a, err_cnt_a;
    logic [AW-1:0]  hd_sum_a, abs_sum_a;
    logic [OW-1:0]  max_a;
    logic           start_b, done_ack_b, busy_b, done_b, sat_b;
    logic [CWB-1:0] win_len_b, sample_cnt_b, err_cnt_b;
    logic [AWB-1:0] hd_sum_b, abs_sum_b;
    logic [OW-1:0]  max_b;
`ifdef BMF_ERR_MONITOR_SQERR_EN
    logic [2*AW-1:0]  sq_a;
    logic [2*AWB-1:0] sq_b;
`endif

    bmf_err_monitor_if #(.OUT_W(OW)) ifa ();
    bmf_err_monitor_if #(.OUT_W(OW)) ifb ();

    bmf_err_monitor #(.OUT_W(OW), .CNT_W(CW), .ACC_W(AW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .win_len(win_len_a), .s_in(ifa.slave),
        .busy(busy_a), .done(done_a), .done_ack(done_ack_a), .sample_cnt(sample_cnt_a),
        .err_cnt(err_cnt_a), .hd_sum(hd_sum_a), .abs_err_sum(abs_sum_a), .max_abs_err(max_a),
        .sat(sat_a)
`ifdef BMF_ERR_MONITOR_SQERR_EN
        , .sq_err_sum(sq_a)
`endif
    );

    bmf_err_monitor #(.OUT_W(OW), .CNT_W(CWB), .ACC_W(AWB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .win_len(win_len_b), .s_in(ifb.slave),
        .busy(busy_b), .done(done_b), .done_ack(done_ack_b), .sample_cnt(sample_cnt_b),
        .err_cnt(err_cnt_b), .hd_sum(hd_sum_b), .abs_err_sum(abs_sum_b), .max_abs_err(max_b),
        .sat(sat_b)
`ifdef BMF_ERR_MONITOR_SQERR_EN
        , .sq_err_sum(sq_b)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [OW-1:0] ex_arr[$];
    logic [OW-1:0] ap_arr[$];

    function automatic longint clampv(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    // Full window on DUT A with the pairs in ex_arr/ap_arr; vmode 0=always valid, 1=toggle, 2=random.
    task automatic run_window(input int wl, input int vmode, input bit poke, input string tag);
        int idx, cyc, lat, xe, xa, d;
        bit v, got;
        longint e_err, e_hd, e_abs, e_max, e_sq;
        bit e_sat;
        e_err = 0; e_hd = 0; e_abs = 0; e_max = 0; e_sq = 0;
        for (int i = 0; i < wl; i++) begin
            xe = int'(ex_arr[i]);
            xa = int'(ap_arr[i]);
            d  = (xe > xa) ? xe - xa : xa - xe;
            e_err += (xe != xa) ? 1 : 0;
            e_hd  += $countones(ex_arr[i] ^ ap_arr[i]);
            e_abs += d;
            e_sq  += d * d;
            if (d > e_max) e_max = d;
        end
        e_sat = (e_hd != clampv(e_hd, AW)) || (e_abs != clampv(e_abs, AW)) || (e_sq != clampv(e_sq, 2*AW));
        e_hd  = clampv(e_hd, AW);
        e_abs = clampv(e_abs, AW);
        e_sq  = clampv(e_sq, 2*AW);

        @(negedge clk);
        start_a = 1'b1; win_len_a = CW'(wl);
        @(negedge clk);
        start_a = 1'b0; win_len_a = CW'($urandom);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got=%b exp=1", tag, busy_a); end

        idx = 0; cyc = 0;
        while (idx < wl && cyc < 300) begin
            case (vmode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            ifa.in_valid   = v;
            ifa.exact_out  = v ? ex_arr[idx] : OW'($urandom);
            ifa.approx_out = v ? ap_arr[idx] : OW'($urandom);
            start_a    = poke && (cyc == 1);
            win_len_a  = CW'(wl + 3);
            done_ack_a = poke && (cyc == 2);
            got = v && (ifa.in_ready === 1'b1);
            @(negedge clk);
            cyc++;
            if (got) idx++;
        end
        start_a = 1'b0; done_ack_a = 1'b0;
        checks++;
        if (idx != wl) begin errors++; $display("FAIL %s accept_count got=%0d exp=%0d", tag, idx, wl); end

        // Surplus pairs must be refused once the window is full.
        ifa.in_valid = 1'b1; ifa.exact_out = 4'hF; ifa.approx_out = 4'h0;
        checks++;
        if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_after_last got=%b exp=0", tag, ifa.in_ready); end

        lat = 0;
        while (done_a !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        ifa.in_valid = 1'b0;
        checks++;
        if (lat != 3) begin errors++; $display("FAIL %s done_latency got=%0d exp=3", tag, lat); end
        checks++;
        if (sample_cnt_a !== CW'(wl)) begin errors++; $display("FAIL %s sample_cnt got=%0d exp=%0d", tag, sample_cnt_a, wl); end
        checks++;
        if (err_cnt_a !== CW'(e_err)) begin errors++; $display("FAIL %s err_cnt got=%0d exp=%0d", tag, err_cnt_a, e_err); end
        checks++;
        if (hd_sum_a !== AW'(e_hd)) begin errors++; $display("FAIL %s hd_sum got=%0d exp=%0d", tag, hd_sum_a, e_hd); end
        checks++;
        if (abs_sum_a !== AW'(e_abs)) begin errors++; $display("FAIL %s abs_err_sum got=%0d exp=%0d", tag, abs_sum_a, e_abs); end
        checks++;
        if (max_a !== OW'(e_max)) begin errors++; $display("FAIL %s max_abs_err got=%0d exp=%0d", tag, max_a, e_max); end
        checks++;
        if (sat_a !== e_sat) begin errors++; $display("FAIL %s sat got=%b exp=%b", tag, sat_a, e_sat); end
`ifdef BMF_ERR_MONITOR_SQERR_EN
        checks++;
        if (sq_a !== (2*AW)'(e_sq)) begin errors++; $display("FAIL %s sq_err_sum got=%0d exp=%0d", tag, sq_a, e_sq); end
`endif

        @(negedge clk);
        checks++;
        if (done_a !== 1'b1) begin errors++; $display("FAIL %s done_held got=%b exp=1", tag, done_a); end
        done_ack_a = 1'b1;
        @(negedge clk);
        done_ack_a = 1'b0;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL %s after_ack done=%b busy=%b exp=0/0", tag, done_a, busy_a);
        end
        checks++;
        if (sample_cnt_a !== CW'(wl)) begin errors++; $display("FAIL %s results_held got=%0d exp=%0d", tag, sample_cnt_a, wl); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, done_a, ifa.in_ready, sat_a, busy_b, done_b, ifb.in_ready, sat_b} !== 8'h00) begin
            errors++; $display("FAIL reset_flags got=%b exp=0", {busy_a, done_a, ifa.in_ready, sat_a, busy_b, done_b, ifb.in_ready, sat_b});
        end
        checks++;
        if (sample_cnt_a !== '0 || err_cnt_a !== '0 || hd_sum_a !== '0 || abs_sum_a !== '0 || max_a !== '0) begin
            errors++; $display("FAIL reset_results got=%0d/%0d/%0d/%0d/%0d exp=0", sample_cnt_a, err_cnt_a, hd_sum_a, abs_sum_a, max_a);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        ex_arr = '{4'd5, 4'd3, 4'd0, 4'd9};
        ap_arr = '{4'd5, 4'd5, 4'd15, 4'd8};
        run_window(4, 0, 1'b0, "basic");
        checks++;
        if (err_cnt_a !== 16'd3 || hd_sum_a !== 24'd7 || abs_sum_a !== 24'd18 || max_a !== 4'd15) begin
            errors++; $display("FAIL basic_const got=%0d/%0d/%0d/%0d exp=3/7/18/15", err_cnt_a, hd_sum_a, abs_sum_a, max_a);
        end
    endtask

    task automatic test_zero_window();
        @(negedge clk);
        start_a = 1'b1; win_len_a = '0;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (done_a !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done_a); end
        checks++;
        if (sample_cnt_a !== '0 || err_cnt_a !== '0 || hd_sum_a !== '0 || abs_sum_a !== '0 || max_a !== '0 || sat_a !== 1'b0) begin
            errors++; $display("FAIL zero_results got=%0d/%0d/%0d/%0d/%0d/%b exp=0", sample_cnt_a, err_cnt_a, hd_sum_a, abs_sum_a, max_a, sat_a);
        end
        done_ack_a = 1'b1;
        @(negedge clk);
        done_ack_a = 1'b0;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL zero_ack done=%b busy=%b exp=0/0", done_a, busy_a); end
    endtask

    task automatic test_toggle_valid();
        ex_arr = '{4'd1, 4'd7, 4'd12};
        ap_arr = '{4'd6, 4'd7, 4'd2};
        run_window(3, 1, 1'b1, "toggle");
    endtask

    task automatic test_saturation();
        int acc, lat;
        @(negedge clk);
        start_b = 1'b1; win_len_b = 4'd15;
        @(negedge clk);
        start_b = 1'b0;
        ifb.in_valid = 1'b1; ifb.exact_out = 4'd0; ifb.approx_out = 4'd15;
        acc = 0; lat = 0;
        while (acc < 15 && lat < 100) begin
            if (ifb.in_ready === 1'b1) acc++;
            @(negedge clk);
            lat++;
        end
        ifb.in_valid = 1'b0;
        lat = 0;
        while (done_b !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (done_b !== 1'b1) begin errors++; $display("FAIL sat_done got=%b exp=1", done_b); end
        checks++;
        if (sample_cnt_b !== 4'd15 || err_cnt_b !== 4'd15) begin
            errors++; $display("FAIL sat_counts got=%0d/%0d exp=15/15", sample_cnt_b, err_cnt_b);
        end
        checks++;
        if (hd_sum_b !== 4'd15 || abs_sum_b !== 4'd15 || max_b !== 4'd15) begin
            errors++; $display("FAIL sat_sums got=%0d/%0d/%0d exp=15/15/15", hd_sum_b, abs_sum_b, max_b);
        end
        checks++;
        if (sat_b !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b exp=1", sat_b); end
`ifdef BMF_ERR_MONITOR_SQERR_EN
        checks++;
        if (sq_b !== 8'd255) begin errors++; $display("FAIL sat_sq got=%0d exp=255", sq_b); end
`endif
        done_ack_b = 1'b1;
        @(negedge clk);
        done_ack_b = 1'b0;
    endtask

    task automatic test_reset_mid_window();
        int acc, cyc;
        bit seen_done;
        @(negedge clk);
        start_a = 1'b1; win_len_a = 16'd4;
        @(negedge clk);
        start_a = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 2 && cyc < 20) begin
            ifa.in_valid = 1'b1; ifa.exact_out = OW'($urandom); ifa.approx_out = OW'($urandom);
            if (ifa.in_ready === 1'b1) acc++;
            @(negedge clk);
            cyc++;
        end
        ifa.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy_a, done_a, ifa.in_ready, sat_a} !== 4'h0 || sample_cnt_a !== '0 || err_cnt_a !== '0 ||
            hd_sum_a !== '0 || abs_sum_a !== '0 || max_a !== '0) begin
            errors++; $display("FAIL mid_reset got flags=%b cnt=%0d err=%0d hd=%0d abs=%0d max=%0d exp=0",
                               {busy_a, done_a, ifa.in_ready, sat_a}, sample_cnt_a, err_cnt_a, hd_sum_a, abs_sum_a, max_a);
        end
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin errors++; $display("FAIL mid_reset_no_done got=1 exp=0"); end
        ex_arr = '{4'd1};
        ap_arr = '{4'd2};
        run_window(1, 0, 1'b0, "post_reset");
        checks++;
        if (err_cnt_a !== 16'd1 || abs_sum_a !== 24'd1) begin
            errors++; $display("FAIL post_reset_const got=%0d/%0d exp=1/1", err_cnt_a, abs_sum_a);
        end
    endtask

    task automatic test_random();
        int wl;
        for (int n = 0; n < 8; n++) begin
            wl = $urandom_range(1, 12);
            ex_arr.delete();
            ap_arr.delete();
            for (int i = 0; i < wl; i++) begin
                ex_arr.push_back(OW'($urandom));
                ap_arr.push_back(($urandom_range(0, 3) == 0) ? ex_arr[i] : OW'($urandom));
            end
            run_window(wl, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
        end
    endtask

`ifdef BMF_ERR_MONITOR_SQERR_EN
    task automatic test_sqerr();
        ex_arr = '{4'd0, 4'd2};
        ap_arr = '{4'd3, 4'd0};
        run_window(2, 0, 1'b1, "sqerr");
        checks++;
        if (sq_a !== 48'd13) begin errors++; $display("FAIL sqerr_const got=%0d exp=13", sq_a); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; done_ack_a = 1'b0; win_len_a = '0;
        start_b = 1'b0; done_ack_b = 1'b0; win_len_b = '0;
        ifa.in_valid = 1'b0; ifa.exact_out = '0; ifa.approx_out = '0;
        ifb.in_valid = 1'b0; ifb.exact_out = '0; ifb.approx_out = '0;
        test_reset();
        test_basic();
        test_zero_window();
        test_toggle_valid();
        test_saturation();
        test_reset_mid_window();
        test_random();
`ifdef BMF_ERR_MONITOR_SQERR_EN
        test_sqerr();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
